button_event: RTL and testbench

BUTTON_EVENT -- requirements
Module: button_event

---
 rtl/button_event_pkg.sv | 18 +
 rtl/button_event_tick_gen.sv | 38 +++
 rtl/button_event.sv | 169 ++++++++++++++++
 tb/tb_button_event.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/button_event_pkg.sv
// Shared types and sizing helpers for the button event decoder.
package button_event_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_WAIT2  = 3'd2,
        ST_PRESS2 = 3'd3,
        ST_LONG   = 3'd4
    } state_e;

    localparam int TICK_W_DFLT = 8;

    function automatic int presc_w(input int div);
        return ($clog2(div) < 1) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/button_event_tick_gen.sv
// Prescaler: one-cycle tick every PRESC_DIV clocks, restartable by i_clear.
module tick_gen
    import button_event_pkg::*;
#(
    parameter int PRESC_DIV = 1000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CW = presc_w(PRESC_DIV);
    localparam logic [CW-1:0] RELOAD = CW'(PRESC_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        if (i_clear || cnt_q == '0) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Purely registered so the FSM's phase-clear decision can depend on it.
    assign o_tick = (cnt_q == '0);

endmodule

// File: rtl/button_event.sv
// Button gesture decoder: press/release edges, click, double-click, long press.
// Optional auto-repeat while long-held: define BUTTON_EVENT_REPEAT_EN.
//
// state   | meaning
// IDLE    | released, no gesture in progress
// PRESS1  | first press held, timing towards long press
// WAIT2   | released after short press, timing double-click window
// PRESS2  | second press of a double-click, waiting for release
// LONG    | long press reached, held
module button_event
    import button_event_pkg::*;
#(
    parameter int PRESC_DIV    = 1000,
    parameter int TICK_W       = TICK_W_DFLT,
    parameter int LONG_TICKS   = 100,
    parameter int DCLICK_TICKS = 25,
    parameter int REPEAT_TICKS = 20
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_deb,
    output logic o_press,
    output logic o_release,
    output logic o_click,
    output logic o_dclick,
    output logic o_long,
    output logic o_repeat,
    output logic o_held
);

    localparam logic [TICK_W-1:0] LONG_LAST = TICK_W'(LONG_TICKS - 1);
    localparam logic [TICK_W-1:0] DCLK_LAST = TICK_W'(DCLICK_TICKS - 1);

    if (LONG_TICKS < 1 || LONG_TICKS >= (2 ** TICK_W)) begin : g_bad_long
        $error("LONG_TICKS out of range for TICK_W");
    end
    if (DCLICK_TICKS < 1 || DCLICK_TICKS >= (2 ** TICK_W)) begin : g_bad_dclick
        $error("DCLICK_TICKS out of range for TICK_W");
    end
    if (REPEAT_TICKS < 1 || REPEAT_TICKS >= (2 ** TICK_W)) begin : g_bad_repeat
        $error("REPEAT_TICKS out of range for TICK_W");
    end

    state_e            state_q;
    logic              deb_q;
    logic [TICK_W-1:0] tick_cnt_q;
    logic              tick;
    logic              rise;
    logic              fall;
    logic              long_hit;
    logic              dclk_hit;
    logic              rep_hit;
    logic              clr_phase;

    assign rise     = i_deb & ~deb_q;
    assign fall     = ~i_deb & deb_q;
    assign long_hit = tick && (tick_cnt_q == LONG_LAST);
    assign dclk_hit = tick && (tick_cnt_q == DCLK_LAST);

    // Any state change restarts both the prescaler and the tick count.
    always_comb begin
        clr_phase = 1'b0;
        case (state_q)
            ST_IDLE:   clr_phase = rise;
            ST_PRESS1: clr_phase = fall | long_hit;
            ST_WAIT2:  clr_phase = rise | dclk_hit;
            ST_PRESS2: clr_phase = fall;
            ST_LONG:   clr_phase = fall;
            default:   clr_phase = 1'b1;
        endcase
    end

    tick_gen #(
        .PRESC_DIV (PRESC_DIV)
    ) u_tick_gen (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (clr_phase),
        .o_tick  (tick)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst || clr_phase) begin
            tick_cnt_q <= '0;
        end else if (tick && tick_cnt_q != '1) begin
            tick_cnt_q <= tick_cnt_q + TICK_W'(1);
        end
    end

`ifdef BUTTON_EVENT_REPEAT_EN
    localparam logic [TICK_W-1:0] REP_LAST = TICK_W'(REPEAT_TICKS - 1);

    logic [TICK_W-1:0] rep_cnt_q;

    assign rep_hit = (state_q == ST_LONG) && tick && !fall && (rep_cnt_q == REP_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst || clr_phase) begin
            rep_cnt_q <= '0;
        end else if (state_q == ST_LONG && tick) begin
            rep_cnt_q <= (rep_cnt_q == REP_LAST) ? '0 : rep_cnt_q + TICK_W'(1);
        end
    end
`else
    assign rep_hit = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            deb_q     <= i_deb;
            o_press   <= 1'b0;
            o_release <= 1'b0;
            o_click   <= 1'b0;
            o_dclick  <= 1'b0;
            o_long    <= 1'b0;
            o_repeat  <= 1'b0;
            o_held    <= 1'b0;
        end else begin
            deb_q     <= i_deb;
            o_press   <= rise;
            o_release <= fall;
            o_held    <= i_deb;
            o_click   <= 1'b0;
            o_dclick  <= 1'b0;
            o_long    <= 1'b0;
            o_repeat  <= rep_hit;
            // Edges are tested before timeouts so an edge wins a same-cycle tie.
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_q <= ST_PRESS1;
                    end
                end
                ST_PRESS1: begin
                    if (fall) begin
                        state_q <= ST_WAIT2;
                    end else if (long_hit) begin
                        state_q <= ST_LONG;
                        o_long  <= 1'b1;
                    end
                end
                ST_WAIT2: begin
                    if (rise) begin
                        state_q  <= ST_PRESS2;
                        o_dclick <= 1'b1;
                    end else if (dclk_hit) begin
                        state_q <= ST_IDLE;
                        o_click <= 1'b1;
                    end
                end
                ST_PRESS2: begin
                    if (fall) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_LONG: begin
                    if (fall) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event.sv
// Scoreboard bench for button_event: expected events are queued with their
// cycle stamps as each gesture is driven, and matched as the DUT pulses.
module tb_button_event;

    localparam int EV_PRESS  = 0;
    localparam int EV_REL    = 1;
    localparam int EV_CLICK  = 2;
    localparam int EV_DCLICK = 3;
    localparam int EV_LONG   = 4;
    localparam int EV_REPEAT = 5;

    typedef struct {
        int cyc;
        int kind;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    logic deb;
    logic o_press, o_release, o_click, o_dclick, o_long, o_repeat, o_held;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    ev_t  exp_q[$];

    button_event #(
        .PRESC_DIV    (4),
        .TICK_W       (8),
        .LONG_TICKS   (10),
        .DCLICK_TICKS (5),
        .REPEAT_TICKS (3)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_deb     (deb),
        .o_press   (o_press),
        .o_release (o_release),
        .o_click   (o_click),
        .o_dclick  (o_dclick),
        .o_long    (o_long),
        .o_repeat  (o_repeat),
        .o_held    (o_held)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input int c);
        ev_t e;
        int  i;
        e.cyc  = c;
        e.kind = kind;
        i = 0;
        while (i < exp_q.size() &&
               (exp_q[i].cyc < c || (exp_q[i].cyc == c && exp_q[i].kind <= kind)))
            i++;
        exp_q.insert(i, e);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every pulse must match the head of the expected queue.
    always @(negedge clk) begin
        logic [5:0] outs;
        ev_t        e;
        outs = {o_repeat, o_long, o_dclick, o_click, o_release, o_press};
        if ((outs[5:2] & (outs[5:2] - 4'd1)) != 4'd0)
            check_eq("gesture_exclusive", 32'(outs[5:2]), 32'(outs[5:2] & ~(outs[5:2] - 4'd1)));
        for (int k = 0; k < 6; k++) begin
            if (outs[k]) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_event_kind", k, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("event_kind", k, e.kind);
                    check_eq("event_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        int t;
        rst = 1'b1;
        deb = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", {o_repeat, o_long, o_dclick, o_click, o_release, o_press, o_held}, 0);
        rst = 1'b0;

        // Single click: 12-cycle press, click 20 cycles after release.
        @(negedge clk);
        t = cyc;
        expect_ev(EV_PRESS, t + 1);
        expect_ev(EV_REL,   t + 13);
        expect_ev(EV_CLICK, t + 33);
        deb = 1'b1;
        wait_to(t + 6);
        check_eq("held_high", o_held, 1);
        wait_to(t + 12);
        deb = 1'b0;
        wait_to(t + 16);
        check_eq("held_low", o_held, 0);
        wait_to(t + 60);
        check_eq("queue_click", exp_q.size(), 0);

        // Double click: press 8, release 8, press, release.
        t = cyc;
        expect_ev(EV_PRESS,  t + 1);
        expect_ev(EV_REL,    t + 9);
        expect_ev(EV_PRESS,  t + 17);
        expect_ev(EV_DCLICK, t + 17);
        expect_ev(EV_REL,    t + 27);
        deb = 1'b1;
        wait_to(t + 8);
        deb = 1'b0;
        wait_to(t + 16);
        deb = 1'b1;
        wait_to(t + 26);
        deb = 1'b0;
        wait_to(t + 80);
        check_eq("queue_dclick", exp_q.size(), 0);

        // Long hold: o_long 40 cycles after o_press, repeats every 12 after.
        t = cyc;
        expect_ev(EV_PRESS, t + 1);
        expect_ev(EV_LONG,  t + 41);
`ifdef BUTTON_EVENT_REPEAT_EN
        expect_ev(EV_REPEAT, t + 53);
        expect_ev(EV_REPEAT, t + 65);
        expect_ev(EV_REPEAT, t + 77);
`endif
        expect_ev(EV_REL, t + 81);
        deb = 1'b1;
        wait_to(t + 80);
        deb = 1'b0;
        wait_to(t + 120);
        check_eq("queue_long", exp_q.size(), 0);

        // Release lands on the 10th tick: release wins, no long, later click.
        t = cyc;
        expect_ev(EV_PRESS, t + 1);
        expect_ev(EV_REL,   t + 41);
        expect_ev(EV_CLICK, t + 61);
        deb = 1'b1;
        wait_to(t + 40);
        deb = 1'b0;
        wait_to(t + 90);
        check_eq("queue_long_tie", exp_q.size(), 0);

        // Second press lands on the 5th window tick: double click, no click.
        t = cyc;
        expect_ev(EV_PRESS,  t + 1);
        expect_ev(EV_REL,    t + 5);
        expect_ev(EV_PRESS,  t + 25);
        expect_ev(EV_DCLICK, t + 25);
        expect_ev(EV_REL,    t + 29);
        deb = 1'b1;
        wait_to(t + 4);
        deb = 1'b0;
        wait_to(t + 24);
        deb = 1'b1;
        wait_to(t + 28);
        deb = 1'b0;
        wait_to(t + 70);
        check_eq("queue_dclick_tie", exp_q.size(), 0);

        // Second press one cycle after the window closes: click, then a new gesture.
        t = cyc;
        expect_ev(EV_PRESS, t + 1);
        expect_ev(EV_REL,   t + 5);
        expect_ev(EV_CLICK, t + 25);
        expect_ev(EV_PRESS, t + 26);
        expect_ev(EV_REL,   t + 30);
        expect_ev(EV_CLICK, t + 50);
        deb = 1'b1;
        wait_to(t + 4);
        deb = 1'b0;
        wait_to(t + 25);
        deb = 1'b1;
        wait_to(t + 29);
        deb = 1'b0;
        wait_to(t + 90);
        check_eq("queue_late_press", exp_q.size(), 0);

        // Reset while in LONG with button held: silent abort, only release later.
        t = cyc;
        expect_ev(EV_PRESS, t + 1);
        expect_ev(EV_LONG,  t + 41);
        expect_ev(EV_REL,   t + 71);
        deb = 1'b1;
        wait_to(t + 44);
        rst = 1'b1;
        wait_to(t + 45);
        check_eq("midreset_outputs", {o_repeat, o_long, o_dclick, o_click, o_release, o_press, o_held}, 0);
        wait_to(t + 47);
        check_eq("midreset_outputs_end", {o_repeat, o_long, o_dclick, o_click, o_release, o_press, o_held}, 0);
        rst = 1'b0;
        wait_to(t + 70);
        deb = 1'b0;
        wait_to(t + 110);
        check_eq("queue_reset", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
